lif_neuron: RTL and testbench
=============================

// Module: lif_neuron
// PURPOSE
//  Leaky integrate-and-fire neuron core; consumes the signed 21-bit weighted-sum stream
//  leaving the 3-stage delay buffer. Integrates valid samples into a membrane potential
//  with shift-based leak and emits a one-cycle spike when the potential reaches threshold.
//  After each spike the core enters a fixed refractory period. Sits directly downstream
//  of the delay buffer and feeds the spike router/counter stage.
// PARAMETERS
//  W             21       data width of input sample and membrane potential (signed)
//  THRESHOLD     1000     firing threshold; spike when v_next >= THRESHOLD (signed, W bits)
//  LEAK_SHIFT    4        leak = v >>> LEAK_SHIFT (arithmetic), subtracted per valid sample
//  V_RESET       0        membrane value loaded on spike
//  V_FLOOR       -65536   lower clamp of membrane potential
//  REFRAC_CYCLES 3        refractory length in clk cycles (>=1)
//  CNT_W         16       width of spike counter
// PORTS
//  clk        in   1      single clock, all logic on posedge
//  rst        in   1      synchronous reset, active-high
//  in_valid   in   1      qualifies in for the current cycle
//  in         in   W      signed weighted-sum sample from delay buffer
//  spike      out  1      one-cycle fire pulse
//  v_mem      out  W      signed membrane potential (registered)
//  refrac     out  1      high while in REFRAC state
//  spike_cnt  out  CNT_W  total spikes since reset, wraps modulo 2^CNT_W
// BEHAVIOUR
//  - One clock domain; reset is synchronous and active-high: on posedge clk with rst=1,
//    state=INTEG, v_mem=0, spike=0, refrac=0, spike_cnt=0, refractory counter=0.
//    rst overrides all other inputs, including mid-refractory and a same-cycle in_valid.
//  - States: INTEG, REFRAC (2 states, encoded in 1 bit).
//  - INTEG, in_valid=1: compute in W+2 bits, sign-extended:
//      v_next = v - (v >>> LEAK_SHIFT) + in
//    then clamp to [V_FLOOR, 2^(W-1)-1].
//    If clamped v_next >= THRESHOLD: v_mem<=V_RESET, spike<=1, spike_cnt+=1,
//    state<=REFRAC, rcnt<=REFRAC_CYCLES. Otherwise v_mem<=clamped v_next, spike<=0.
//  - INTEG, in_valid=0: v_mem holds (no leak), spike<=0.
//  - REFRAC: in is ignored regardless of in_valid; v_mem holds V_RESET.
//    rcnt decrements every clk. When rcnt==1, state<=INTEG; the next cycle accepts input.
//    refrac=1 for exactly REFRAC_CYCLES cycles, starting the cycle spike=1.
//  - Latency: a sample at edge N is reflected in v_mem/spike after edge N; single cycle,
//    no backpressure. The upstream buffer free-runs, so samples in REFRAC are dropped.
//  - spike is high for exactly one cycle per fire. Back-to-back spikes are separated
//    by at least REFRAC_CYCLES+1 cycles.
//  - spike_cnt wraps from all-ones to 0 without a flag.
//  - Saturation is silent; the clamp applies before the threshold compare.
// TESTING
//  1 rst=1 two cycles, in_valid=1 in=500 -> v_mem=0, spike=0, refrac=0, spike_cnt=0.
//  2 defaults, in=600 valid two cycles -> v_mem=600, then 600-37+600=1163>=1000:
//    spike=1 one cycle, v_mem=0, refrac=1 for 3 cycles, spike_cnt=1.
//  3 in=2000 valid during all 3 REFRAC cycles -> no spike, v_mem=0;
//    first valid 2000 after refrac drops -> spike=1, spike_cnt=2.
//  4 in=-1048576 valid -> v_mem=-65536 (floor); repeat -> -65536+4096-1048576 clamps
//    to -65536; in_valid=0 for 5 cycles -> v_mem stays -65536.
//  5 rst=1 during REFRAC cycle 2 -> next cycle refrac=0, state INTEG;
//    in=600 valid -> v_mem=600, no spike.
//  6 CNT_W=4, in=1000 valid, 16 fires -> spike_cnt goes 15 then 0, each spike 1 cycle wide.

Source files
------------

// File: rtl/lif_neuron.sv
// Leaky integrate-and-fire neuron: shift-leak integration with clamp, threshold spike,
// fixed refractory window and a wrapping spike counter.
module lif_neuron #(
  parameter int                   W             = 21,
  parameter logic signed [W-1:0]  THRESHOLD     = 21'sd1000,
  parameter int                   LEAK_SHIFT    = 4,
  parameter logic signed [W-1:0]  V_RESET       = 21'sd0,
  parameter logic signed [W-1:0]  V_FLOOR       = -21'sd65536,
  parameter int                   REFRAC_CYCLES = 3,
  parameter int                   CNT_W         = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  input  logic signed [W-1:0] in,
  output logic                spike,
  output logic signed [W-1:0] v_mem,
  output logic                refrac,
  output logic [CNT_W-1:0]    spike_cnt
);

  localparam int RC_W = (REFRAC_CYCLES > 1) ? $clog2(REFRAC_CYCLES + 1) : 1;
  localparam logic [RC_W-1:0]         RC_LOAD = RC_W'(REFRAC_CYCLES);
  localparam logic [RC_W-1:0]         RC_ONE  = RC_W'(1);
  localparam logic [CNT_W-1:0]        CNT_ONE = CNT_W'(1);
  localparam logic signed [W+1:0]     C_FLOOR = (W+2)'(V_FLOOR);
  localparam logic signed [W+1:0]     C_MAX   = (W+2)'({1'b0, {(W-1){1'b1}}});

  typedef enum logic {S_INTEG = 1'b0, S_REFRAC = 1'b1} state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic signed [W-1:0]   r_v;
  logic                  r_spike;
  logic [CNT_W-1:0]      r_cnt;
  logic [RC_W-1:0]       r_rcnt;

  logic signed [W-1:0]   w_leak;
  logic signed [W+1:0]   w_v_ext;
  logic signed [W+1:0]   w_leak_ext;
  logic signed [W+1:0]   w_in_ext;
  logic signed [W+1:0]   w_sum;
  logic signed [W-1:0]   w_clamp;
  logic                  w_fire;
  logic signed [W-1:0]   w_v_nxt;
  logic                  w_spike_nxt;
  logic [CNT_W-1:0]      w_cnt_nxt;
  logic [RC_W-1:0]       w_rcnt_nxt;

  // Widen by two bits so leak subtraction plus input cannot overflow before the clamp.
  always_comb begin
    w_leak     = r_v >>> LEAK_SHIFT;
    w_v_ext    = {{2{r_v[W-1]}}, r_v};
    w_leak_ext = {{2{w_leak[W-1]}}, w_leak};
    w_in_ext   = {{2{in[W-1]}}, in};
    w_sum      = w_v_ext - w_leak_ext + w_in_ext;
    if (w_sum < C_FLOOR) begin
      w_clamp = V_FLOOR;
    end else if (w_sum > C_MAX) begin
      w_clamp = C_MAX[W-1:0];
    end else begin
      w_clamp = w_sum[W-1:0];
    end
    w_fire = in_valid && (r_state == S_INTEG) && (w_clamp >= THRESHOLD);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_INTEG;
      r_v     <= '0;
      r_spike <= 1'b0;
      r_cnt   <= '0;
      r_rcnt  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_v     <= w_v_nxt;
      r_spike <= w_spike_nxt;
      r_cnt   <= w_cnt_nxt;
      r_rcnt  <= w_rcnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_INTEG:  w_state_nxt = w_fire ? S_REFRAC : S_INTEG;
      S_REFRAC: w_state_nxt = (r_rcnt == RC_ONE) ? S_INTEG : S_REFRAC;
      default:  w_state_nxt = S_INTEG;
    endcase
  end

  // Samples arriving during the refractory window are dropped; the membrane stays put.
  always_comb begin
    w_v_nxt     = r_v;
    w_spike_nxt = 1'b0;
    w_cnt_nxt   = r_cnt;
    w_rcnt_nxt  = r_rcnt;
    case (r_state)
      S_INTEG: begin
        if (w_fire) begin
          w_v_nxt     = V_RESET;
          w_spike_nxt = 1'b1;
          w_cnt_nxt   = r_cnt + CNT_ONE;
          w_rcnt_nxt  = RC_LOAD;
        end else if (in_valid) begin
          w_v_nxt = w_clamp;
        end else begin
          w_v_nxt = r_v;
        end
      end
      S_REFRAC: begin
        w_rcnt_nxt = r_rcnt - RC_ONE;
      end
      default: begin
        w_v_nxt = r_v;
      end
    endcase
  end

  assign spike     = r_spike;
  assign v_mem     = r_v;
  assign refrac    = (r_state == S_REFRAC);
  assign spike_cnt = r_cnt;

endmodule

// File: tb/tb_lif_neuron.sv
// Directed plus randomized bench for lif_neuron, checked against a cycle-level
// behavioural model (remaining-refractory-cycles counter and integer arithmetic).
module tb_lif_neuron;
  logic               clk;
  logic               rst;
  logic               in_valid;
  logic signed [20:0] in_s;
  logic               spike_a, refrac_a, spike_b, refrac_b;
  logic signed [20:0] v_mem_a, v_mem_b;
  logic [15:0]        cnt_a;
  logic [3:0]         cnt_b;

  int n_cmp = 0;
  int n_bad = 0;

  // reference model state
  int m_v, m_left, m_cnt;
  bit m_spike;

  lif_neuron u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in(in_s),
    .spike(spike_a), .v_mem(v_mem_a), .refrac(refrac_a), .spike_cnt(cnt_a)
  );

  lif_neuron #(.CNT_W(4)) u_dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in(in_s),
    .spike(spike_b), .v_mem(v_mem_b), .refrac(refrac_b), .spike_cnt(cnt_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_step(input bit r, input bit vld, input int x);
    int nv;
    if (r) begin
      m_v = 0; m_left = 0; m_cnt = 0; m_spike = 0;
    end else if (m_left > 0) begin
      m_left--; m_spike = 0;
    end else if (vld) begin
      nv = m_v - (m_v >>> 4) + x;
      if (nv < -65536) nv = -65536;
      if (nv > 1048575) nv = 1048575;
      if (nv >= 1000) begin
        m_v = 0; m_spike = 1; m_cnt++; m_left = 3;
      end else begin
        m_v = nv; m_spike = 0;
      end
    end else begin
      m_spike = 0;
    end
  endtask

  task automatic cycle(input bit r, input bit vld, input int x);
    @(negedge clk);
    rst = r; in_valid = vld; in_s = 21'(x);
    @(posedge clk);
    model_step(r, vld, x);
    #1;
    check_val("v_mem",     int'(v_mem_a), m_v);
    check_val("spike",     int'(spike_a), int'(m_spike));
    check_val("refrac",    int'(refrac_a), (m_left > 0) ? 1 : 0);
    check_val("spike_cnt", int'(cnt_a), m_cnt % 65536);
    check_val("cnt4",      int'(cnt_b), m_cnt % 16);
    check_val("spike4",    int'(spike_b), int'(m_spike));
  endtask

  initial begin
    int x;
    bit v, r;
    rst = 1'b1; in_valid = 1'b0; in_s = '0;
    m_v = 0; m_left = 0; m_cnt = 0; m_spike = 0;
    // reset with active input
    cycle(1'b1, 1'b1, 500);
    cycle(1'b1, 1'b1, 500);
    // integrate then fire, refractory drops input, fire again
    cycle(1'b0, 1'b1, 600);
    check_val("v600", int'(v_mem_a), 600);
    cycle(1'b0, 1'b1, 600);
    check_val("fire1", int'(spike_a), 1);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 2000);
    check_val("refrac_end", int'(refrac_a), 0);
    cycle(1'b0, 1'b1, 2000);
    check_val("cnt2", int'(cnt_a), 2);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 0);
    // floor clamp and hold
    cycle(1'b0, 1'b1, -1048576);
    cycle(1'b0, 1'b1, -1048576);
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 0);
    check_val("floor", int'(v_mem_a), -65536);
    // reset mid-refractory
    cycle(1'b1, 1'b0, 0);
    cycle(1'b0, 1'b1, 2000);
    cycle(1'b0, 1'b1, 2000);
    cycle(1'b1, 1'b1, 2000);
    check_val("rst_refrac", int'(refrac_a), 0);
    cycle(1'b0, 1'b1, 600);
    check_val("post_rst", int'(v_mem_a), 600);
    // counter wrap on the 4-bit instance
    cycle(1'b1, 1'b0, 0);
    for (int i = 0; i < 17; i++) begin
      cycle(1'b0, 1'b1, 1000);
      for (int j = 0; j < 3; j++) cycle(1'b0, 1'b0, 0);
    end
    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      r = ($urandom_range(0, 99) == 0);
      v = ($urandom_range(0, 9) < 7);
      case ($urandom_range(0, 3))
        0: x = int'($urandom_range(0, 400));
        1: x = -int'($urandom_range(0, 70000));
        2: x = int'($urandom_range(0, 2097151)) - 1048576;
        default: x = int'($urandom_range(0, 1200)) - 200;
      endcase
      cycle(r, v, x);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
